// File: rtl/pin_test_gen.sv
// Board pin test pattern generator: LFSR/walking/checkerboard patterns, a free-running divided
// clock, and a two-flop-synchronised loopback checker with a saturating error counter.
module pin_test_gen #(
  parameter int unsigned      WIDTH    = 54,
  parameter logic [WIDTH-1:0] TAPS     = 54'h30_0000_0003_0000,
  parameter int unsigned      CLK_DIV  = 4,
  parameter int unsigned      STEP_DIV = 1,
  parameter int unsigned      LB_BIT   = 0
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             chk_en,
  input  logic             lb_in,
  output logic [WIDTH-1:0] pat_out,
  output logic             ck_out,
  output logic             step,
  output logic [15:0]      err_cnt,
  output logic             err
);

  localparam logic [1:0] ModeLfsr  = 2'b00;
  localparam logic [1:0] ModeWalk1 = 2'b01;
  localparam logic [1:0] ModeWalk0 = 2'b10;

  localparam int unsigned CkMax = CLK_DIV / 2 - 1;
  localparam int unsigned CkW   = (CkMax > 0) ? $clog2(CkMax + 1) : 1;
  localparam int unsigned PsMax = STEP_DIV - 1;
  localparam int unsigned PsW   = (PsMax > 0) ? $clog2(PsMax + 1) : 1;

  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      ModeLfsr:  s = '0;
      ModeWalk1: s = WIDTH'(1);
      ModeWalk0: s = ~WIDTH'(1);
      default: begin
        for (int i = 0; i < WIDTH; i++) s[i] = (i % 2 == 0);
      end
    endcase
    return s;
  endfunction

  logic [1:0]       mode_q;
  logic [PsW-1:0]   psc_q;
  logic [CkW-1:0]   ck_div_q;
  logic [WIDTH-1:0] pat_nxt;
  logic             reload;
  logic             psc_wrap;

  assign reload   = (mode != mode_q);
  assign psc_wrap = (psc_q == PsW'(PsMax));
  assign step     = en & psc_wrap & ~reload & ~rst;

  always_comb begin
    pat_nxt = pat_out;
    case (mode_q)
      ModeLfsr:             pat_nxt = {pat_out[WIDTH-2:0], ~^(pat_out & TAPS)};
      ModeWalk1, ModeWalk0: pat_nxt = {pat_out[WIDTH-2:0], pat_out[WIDTH-1]};
      default:              pat_nxt = ~pat_out;
    endcase
  end

  // Divided clock runs regardless of en/mode so the peripheral never sees a glitch.
  always_ff @(posedge fclk) begin
    if (rst) begin
      ck_div_q <= '0;
      ck_out   <= 1'b0;
    end else if (ck_div_q == CkW'(CkMax)) begin
      ck_div_q <= '0;
      ck_out   <= ~ck_out;
    end else begin
      ck_div_q <= ck_div_q + CkW'(1);
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      mode_q  <= mode;
      pat_out <= seed_of(mode);
      psc_q   <= '0;
    end else begin
      mode_q <= mode;
      if (reload) begin
        pat_out <= seed_of(mode);
        psc_q   <= '0;
      end else if (en) begin
        if (psc_wrap) begin
          psc_q   <= '0;
          pat_out <= pat_nxt;
        end else begin
          psc_q <= psc_q + PsW'(1);
        end
      end
    end
  end

  logic       lb_meta_q, lb_sync_q;
  logic       exp_d1_q, exp_d2_q;
  logic [1:0] vld_q;
  logic       chk_en_q;
  logic       chk_rise;
  logic       hit;

  assign chk_rise = chk_en & ~chk_en_q;
  assign hit      = chk_en & (vld_q == 2'd2) & (lb_sync_q != exp_d2_q);

  // Expected bit is delayed to line up with the two-flop synchroniser on lb_in.
  always_ff @(posedge fclk) begin
    if (rst) begin
      lb_meta_q <= 1'b0;
      lb_sync_q <= 1'b0;
      exp_d1_q  <= 1'b0;
      exp_d2_q  <= 1'b0;
      vld_q     <= 2'd0;
      chk_en_q  <= 1'b0;
      err_cnt   <= 16'h0000;
      err       <= 1'b0;
    end else begin
      lb_meta_q <= lb_in;
      lb_sync_q <= lb_meta_q;
      exp_d1_q  <= pat_out[LB_BIT];
      exp_d2_q  <= exp_d1_q;
      chk_en_q  <= chk_en;
      if (reload)              vld_q <= 2'd0;
      else if (vld_q != 2'd2)  vld_q <= vld_q + 2'd1;
      if (chk_rise) begin
        err_cnt <= 16'h0000;
        err     <= 1'b0;
      end else if (hit) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pin_test_gen.sv
// Directed bench for pin_test_gen: default LFSR start-up, slow walking-one with enable gating,
// a vector table of mode switches on an 8-bit instance, and loopback error counting.
module tb_pin_test_gen;

  logic fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Instance A: all defaults
  logic        a_rst = 1'b1, a_en = 1'b0, a_ck, a_step, a_err;
  logic [1:0]  a_mode = 2'b00;
  logic [53:0] a_pat;
  logic [15:0] a_cnt;
  pin_test_gen u_a (
    .fclk(fclk), .rst(a_rst), .en(a_en), .mode(a_mode), .chk_en(1'b0), .lb_in(1'b0),
    .pat_out(a_pat), .ck_out(a_ck), .step(a_step), .err_cnt(a_cnt), .err(a_err)
  );

  // Instance B: 8-bit, step every 3rd cycle
  logic        b_rst = 1'b1, b_en = 1'b0, b_ck, b_step, b_err;
  logic [1:0]  b_mode = 2'b01;
  logic [7:0]  b_pat;
  logic [15:0] b_cnt;
  pin_test_gen #(.WIDTH(8), .TAPS(8'hB8), .STEP_DIV(3)) u_b (
    .fclk(fclk), .rst(b_rst), .en(b_en), .mode(b_mode), .chk_en(1'b0), .lb_in(1'b0),
    .pat_out(b_pat), .ck_out(b_ck), .step(b_step), .err_cnt(b_cnt), .err(b_err)
  );

  // Instance C: 8-bit, step every cycle, loopback under bench control
  logic        c_rst = 1'b1, c_en = 1'b0, c_chk = 1'b0, c_lb, c_ck, c_step, c_err;
  logic [1:0]  c_mode = 2'b11;
  logic [7:0]  c_pat;
  logic [15:0] c_cnt;
  int          lb_sel = 0;  // 0 tied, 1 forced low, 2 inverted
  assign c_lb = (lb_sel == 0) ? c_pat[0] : (lb_sel == 1) ? 1'b0 : ~c_pat[0];
  pin_test_gen #(.WIDTH(8), .TAPS(8'hB8), .STEP_DIV(1)) u_c (
    .fclk(fclk), .rst(c_rst), .en(c_en), .mode(c_mode), .chk_en(c_chk), .lb_in(c_lb),
    .pat_out(c_pat), .ck_out(c_ck), .step(c_step), .err_cnt(c_cnt), .err(c_err)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic [7:0] pat;
    logic       step;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  initial begin
    logic [7:0]  exp_b;
    logic [53:0] exp_a [5];
    logic [15:0] c0;
    int          n_en;
    int          guard;

    // {en, mode, pat seen this cycle, step this cycle}
    vecs[0]  = '{1'b1, 2'b11, 8'h55, 1'b1};
    vecs[1]  = '{1'b1, 2'b11, 8'hAA, 1'b1};
    vecs[2]  = '{1'b1, 2'b11, 8'h55, 1'b1};
    vecs[3]  = '{1'b1, 2'b10, 8'hAA, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 8'hFE, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 8'hFD, 1'b1};
    vecs[6]  = '{1'b0, 2'b10, 8'hFB, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 8'hFB, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 8'hFB, 1'b1};
    vecs[9]  = '{1'b1, 2'b01, 8'hF7, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 8'h01, 1'b1};
    vecs[11] = '{1'b1, 2'b01, 8'h02, 1'b1};
    vecs[12] = '{1'b1, 2'b00, 8'h04, 1'b0};
    vecs[13] = '{1'b1, 2'b00, 8'h00, 1'b1};
    vecs[14] = '{1'b1, 2'b00, 8'h01, 1'b1};
    vecs[15] = '{1'b1, 2'b00, 8'h03, 1'b1};
    vecs[16] = '{1'b1, 2'b00, 8'h07, 1'b1};
    vecs[17] = '{1'b1, 2'b00, 8'h0F, 1'b1};
    vecs[18] = '{1'b1, 2'b00, 8'h1E, 1'b1};

    // Default instance, LFSR from the all-zero seed
    exp_a[0] = 54'h0; exp_a[1] = 54'h1; exp_a[2] = 54'h3; exp_a[3] = 54'h7; exp_a[4] = 54'hF;
    a_rst = 1'b1; a_mode = 2'b00; a_en = 1'b1;
    tick();
    a_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge fclk);
      check($sformatf("a_pat[%0d]", i), 64'(a_pat), 64'(exp_a[i]));
      check($sformatf("a_step[%0d]", i), 64'(a_step), 64'd1);
      tick();
    end

    // Walking one, STEP_DIV=3, enable dropped mid-step for 5 cycles
    b_rst = 1'b1; b_mode = 2'b01; b_en = 1'b1;
    tick();
    b_rst = 1'b0;
    n_en = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      b_en = !(cyc >= 10 && cyc < 15);
      @(negedge fclk);
      exp_b = 8'h01 << ((n_en / 3) % 8);
      check($sformatf("b_pat[%0d]", cyc), 64'(b_pat), 64'(exp_b));
      check($sformatf("b_step[%0d]", cyc), 64'(b_step), 64'(b_en && (n_en % 3 == 2)));
      if (b_en) n_en++;
      tick();
    end

    // Vector table: mode switches, en gating, free-running ck_out
    c_rst = 1'b1; c_mode = 2'b11; c_en = 1'b0; c_chk = 1'b0; lb_sel = 0;
    tick();
    c_rst = 1'b0;
    check("c_reset_cnt", 64'(c_cnt), 64'd0);
    check("c_reset_err", 64'(c_err), 64'd0);
    for (int k = 0; k < NVec; k++) begin
      c_en   = vecs[k].en;
      c_mode = vecs[k].mode;
      @(negedge fclk);
      check($sformatf("c_pat[%0d]", k), 64'(c_pat), 64'(vecs[k].pat));
      check($sformatf("c_step[%0d]", k), 64'(c_step), 64'(vecs[k].step));
      check($sformatf("c_ck[%0d]", k), 64'(c_ck), 64'((k >> 1) & 1));
      tick();
    end

    // Compare-valid hold after reset with inverted loopback
    c_rst = 1'b1; c_mode = 2'b11; c_en = 1'b1; c_chk = 1'b1; lb_sel = 2;
    tick();
    c_rst = 1'b0;
    tick();
    check("valid_hold_1", 64'(c_cnt), 64'd0);
    tick();
    check("valid_hold_2", 64'(c_cnt), 64'd0);
    tick();
    check("first_count", 64'(c_cnt), 64'd1);
    check("first_err", 64'(c_err), 64'd1);

    // Tied loopback after a chk_en rising-edge clear
    lb_sel = 0; c_chk = 1'b0;
    tick();
    c_chk = 1'b1;
    tick();
    check("rise_clear_cnt", 64'(c_cnt), 64'd0);
    check("rise_clear_err", 64'(c_err), 64'd0);
    repeat (20) tick();
    check("tied_cnt", 64'(c_cnt), 64'd0);
    check("tied_err", 64'(c_err), 64'd0);

    // Forced-low loopback against checkerboard: one mismatch every other cycle
    lb_sel = 1;
    repeat (4) tick();
    c0 = c_cnt;
    repeat (10) tick();
    check("alt_growth", 64'(c_cnt), 64'(c0 + 16'd5));
    check("alt_err", 64'(c_err), 64'd1);

    // Clear while mismatching, count up to 5, then reset mid-run
    c_chk = 1'b0;
    tick();
    c_chk = 1'b1;
    tick();
    check("clear_during_miss", 64'(c_cnt), 64'd0);
    guard = 0;
    while (c_cnt != 16'd5 && guard < 50) begin
      tick();
      guard++;
    end
    check("reach_5", 64'(c_cnt), 64'd5);
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    check("rst_cnt", 64'(c_cnt), 64'd0);
    check("rst_err", 64'(c_err), 64'd0);
    check("rst_pat", 64'(c_pat), 64'h55);
    check("rst_ck", 64'(c_ck), 64'd0);

    // Permanent mismatch saturates the counter
    lb_sel = 2;
    repeat (70000) tick();
    check("sat_cnt", 64'(c_cnt), 64'hFFFF);
    check("sat_err", 64'(c_err), 64'd1);
    tick();
    check("sat_hold", 64'(c_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
